tx_voq_scheduler: RTL

//  Next-generation TX egress control: round-robin arbitration over NUM_VOQ virtual output queues.
//  For each granted frame: issues a memory read start pointer, writes preamble/SFD, then streams frame bytes.

---
 rtl/tx_voq_scheduler_if.sv | 43 ++++
 rtl/tx_voq_scheduler.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/tx_voq_scheduler_if.sv
// Switch-clock side bundle of the TX VOQ scheduler:
// VOQ request/grant, memory read stream, CDC FIFO write port and status.
interface tx_voq_scheduler_if #(
  parameter int NUM_VOQ = 4,
  parameter int PTR_W   = 6
);
  logic [NUM_VOQ-1:0]       voq_valid_i;
  logic [NUM_VOQ*PTR_W-1:0] voq_ptr_i;
  logic [NUM_VOQ-1:0]       voq_ready_o;
  logic                     mem_req_o;
  logic [PTR_W-1:0]         mem_ptr_o;
  logic [7:0]               frame_data_i;
  logic                     frame_valid_i;
  logic                     frame_eof_i;
  logic                     frame_ready_o;
  logic                     fifo_wr_en_o;
  logic [7:0]               fifo_din_o;
  logic                     fifo_full_i;
  logic                     busy_o;
  logic [31:0]              tx_frame_count_o;
  logic                     err_runt_o;
  logic                     err_giant_o;

  modport master (
    output voq_valid_i, voq_ptr_i,
    output frame_data_i, frame_valid_i, frame_eof_i,
    output fifo_full_i,
    input  voq_ready_o, mem_req_o, mem_ptr_o,
    input  frame_ready_o, fifo_wr_en_o, fifo_din_o,
    input  busy_o, tx_frame_count_o,
    input  err_runt_o, err_giant_o
  );

  modport slave (
    input  voq_valid_i, voq_ptr_i,
    input  frame_data_i, frame_valid_i, frame_eof_i,
    input  fifo_full_i,
    output voq_ready_o, mem_req_o, mem_ptr_o,
    output frame_ready_o, fifo_wr_en_o, fifo_din_o,
    output busy_o, tx_frame_count_o,
    output err_runt_o, err_giant_o
  );
endinterface

// File: rtl/tx_voq_scheduler.sv
// TX egress control: round-robin VOQ grant, preamble/SFD insertion,
// frame streaming into the CDC FIFO with runt/giant handling and IFG.
module tx_voq_scheduler #(
  parameter int NUM_VOQ         = 4,
  parameter int PTR_W           = 6,
  parameter int PREAMBLE_LEN    = 8,
  parameter int MIN_FRAME_BYTES = 64,
  parameter int MAX_FRAME_BYTES = 1518,
  parameter int IFG_CYCLES      = 48
) (
  input  logic               switch_clk,
  input  logic               switch_rst,
  tx_voq_scheduler_if.slave  bus
);

  localparam int LW  = (NUM_VOQ > 1) ? $clog2(NUM_VOQ) : 1;
  localparam int PRW = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;
  localparam int BW  = $clog2(MAX_FRAME_BYTES + 1);
  localparam int IW  = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;

  localparam logic [PRW-1:0] PRE_LAST = PRW'(PREAMBLE_LEN - 1);
  localparam logic [BW-1:0]  MAX_B    = BW'(MAX_FRAME_BYTES);
  localparam logic [BW-1:0]  MIN_B    = BW'(MIN_FRAME_BYTES);
  localparam logic [IW-1:0]  IFG_LAST = IW'(IFG_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
    S_DROP,
    S_IFG
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [LW-1:0]        r_last, w_last_nxt;
  logic [PRW-1:0]       r_pre, w_pre_nxt;
  logic [BW-1:0]        r_byte, w_byte_nxt;
  logic [IW-1:0]        r_ifg, w_ifg_nxt;
  logic [NUM_VOQ-1:0]   r_voq_ready, w_voq_ready_nxt;
  logic                 r_mem_req, w_mem_req_nxt;
  logic [PTR_W-1:0]     r_mem_ptr, w_mem_ptr_nxt;
  logic [31:0]          r_frame_cnt, w_frame_cnt_nxt;
  logic                 r_runt, w_runt_nxt;
  logic                 r_giant, w_giant_nxt;

  logic                 w_found;
  logic [LW-1:0]        w_win;
  logic [BW-1:0]        w_byte_inc;
  logic                 w_wr_en;
  logic [7:0]           w_din;
  logic                 w_frame_ready;
  logic [PTR_W-1:0]     w_ptrs [NUM_VOQ];

  for (genvar g = 0; g < NUM_VOQ; g++) begin : g_ptr
    assign w_ptrs[g] = bus.voq_ptr_i[g*PTR_W +: PTR_W];
  end

  function automatic logic [LW-1:0] f_idx(input logic [LW-1:0] base,
                                          input int k);
    return LW'((int'(base) + k) % NUM_VOQ);
  endfunction

  // Search starts one past the last grant so every VOQ gets a turn
  always_comb begin
    w_found = 1'b0;
    w_win   = r_last;
    for (int k = 1; k <= NUM_VOQ; k++) begin
      if (!w_found && bus.voq_valid_i[f_idx(r_last, k)]) begin
        w_found = 1'b1;
        w_win   = f_idx(r_last, k);
      end
    end
  end

  assign w_byte_inc = r_byte + BW'(1);

  always_comb begin
    w_state_nxt     = r_state;
    w_last_nxt      = r_last;
    w_pre_nxt       = r_pre;
    w_byte_nxt      = r_byte;
    w_ifg_nxt       = r_ifg;
    w_voq_ready_nxt = '0;
    w_mem_req_nxt   = 1'b0;
    w_mem_ptr_nxt   = r_mem_ptr;
    w_frame_cnt_nxt = r_frame_cnt;
    w_runt_nxt      = 1'b0;
    w_giant_nxt     = 1'b0;
    w_wr_en         = 1'b0;
    w_din           = 8'h00;
    w_frame_ready   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_voq_ready_nxt[w_win] = 1'b1;
          w_mem_req_nxt          = 1'b1;
          w_mem_ptr_nxt          = w_ptrs[w_win];
          w_last_nxt             = w_win;
          w_pre_nxt              = '0;
          w_state_nxt            = S_PRE;
        end
      end
      S_PRE: begin
        if (!bus.fifo_full_i) begin
          w_wr_en = 1'b1;
          if (r_pre == PRE_LAST) begin
            w_din       = 8'hD5;
            w_byte_nxt  = '0;
            w_state_nxt = S_DATA;
          end else begin
            w_din     = 8'h55;
            w_pre_nxt = r_pre + PRW'(1);
          end
        end
      end
      S_DATA: begin
        w_frame_ready = !bus.fifo_full_i;
        if (bus.frame_valid_i && !bus.fifo_full_i) begin
          w_wr_en    = 1'b1;
          w_din      = bus.frame_data_i;
          w_byte_nxt = w_byte_inc;
          if (bus.frame_eof_i) begin
            w_runt_nxt      = (w_byte_inc < MIN_B);
            w_frame_cnt_nxt = r_frame_cnt + 32'd1;
            w_ifg_nxt       = '0;
            w_state_nxt     = S_IFG;
          end else if (w_byte_inc == MAX_B) begin
            w_state_nxt = S_DROP;
          end
        end
      end
      // Oversize tail is drained from memory without touching the FIFO
      S_DROP: begin
        w_frame_ready = 1'b1;
        if (bus.frame_valid_i && bus.frame_eof_i) begin
          w_giant_nxt     = 1'b1;
          w_frame_cnt_nxt = r_frame_cnt + 32'd1;
          w_ifg_nxt       = '0;
          w_state_nxt     = S_IFG;
        end
      end
      S_IFG: begin
        if (r_ifg == IFG_LAST) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_ifg_nxt = r_ifg + IW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge switch_clk) begin
    if (switch_rst) begin
      r_state     <= S_IDLE;
      r_last      <= LW'(NUM_VOQ - 1);
      r_pre       <= '0;
      r_byte      <= '0;
      r_ifg       <= '0;
      r_voq_ready <= '0;
      r_mem_req   <= 1'b0;
      r_mem_ptr   <= '0;
      r_frame_cnt <= '0;
      r_runt      <= 1'b0;
      r_giant     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_last      <= w_last_nxt;
      r_pre       <= w_pre_nxt;
      r_byte      <= w_byte_nxt;
      r_ifg       <= w_ifg_nxt;
      r_voq_ready <= w_voq_ready_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_ptr   <= w_mem_ptr_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_runt      <= w_runt_nxt;
      r_giant     <= w_giant_nxt;
    end
  end

  assign bus.voq_ready_o      = r_voq_ready;
  assign bus.mem_req_o        = r_mem_req;
  assign bus.mem_ptr_o        = r_mem_ptr;
  assign bus.tx_frame_count_o = r_frame_cnt;
  assign bus.err_runt_o       = r_runt;
  assign bus.err_giant_o      = r_giant;
  assign bus.fifo_wr_en_o     = w_wr_en;
  assign bus.fifo_din_o       = w_din;
  assign bus.frame_ready_o    = w_frame_ready;
  assign bus.busy_o           = (r_state != S_IDLE);

endmodule
